// File: rtl/fp_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_divider_pkg
// Description : Shared types and constants for the iterative binary32
//               divider: FSM state, rounding-mode codes, special-result
//               encodings and the registered result record.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_divider_pkg;

  // Divider control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Rounding-mode codes as understood by the post-processing stage
  localparam logic [2:0] FPU_RM_RNE = 3'b000;
  localparam logic [2:0] FPU_RM_RTZ = 3'b001;
  localparam logic [2:0] FPU_RM_RDN = 3'b010;
  localparam logic [2:0] FPU_RM_RUP = 3'b011;
  localparam logic [2:0] FPU_RM_RMM = 3'b100;

  // Special-result encodings (biased exponent carried in exp[7:0])
  localparam logic [23:0] FPU_CANON_NAN_MAN = 24'h400000;
  localparam logic [23:0] FPU_INF_MAN       = 24'h000000;
  localparam logic [9:0]  FPU_SPECIAL_EXP   = 10'h0ff;

  // Quotient bits produced per operation, minus one (counter start value)
  localparam logic [4:0] DIV_ITER_LAST = 5'd24;

  // Everything handed to the post-processor alongside valid_out
  typedef struct packed {
    logic [2:0]  rm;
    logic [23:0] man;
    logic [9:0]  exp;
    logic        sgn;
    logic        rnd;
    logic        sticky;
    logic        skip;
    logic        iv;
    logic        dz;
  } div_result_t;

  // True for any NaN encoding (all-ones exponent, non-zero fraction)
  function automatic logic is_nan(input logic [31:0] x);
    return (&x[30:23]) & (|x[22:0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_divider_leading_zero_counter.sv
`default_nettype none
// ============================================================================
// Module      : leading_zero_counter
// Description : Counts leading zeros of a vector, MSB first. An all-zero
//               input returns WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module leading_zero_counter #(
  parameter int WIDTH = 24,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CNT_W-1:0] o_count
);

  // Scan upward so the highest set bit is the last one to set the count
  always_comb begin
    o_count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i]) o_count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_divider.sv
`default_nettype none
// ============================================================================
// Module      : fp_divider
// Description : Iterative binary32 divider (a / b). Classifies operands,
//               normalises denormals, runs a 25-step radix-2 restoring
//               mantissa division and hands an unrounded result (or a fully
//               formed special result) to the rounding stage.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_divider
  import fp_divider_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        valid_out,
  input  logic        ready_in,
  input  logic [2:0]  rm,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [2:0]  rm_out,
  output logic [23:0] man_out,
  output logic [9:0]  exp_out,
  output logic        sgn_out,
  output logic        round_bit,
  output logic        sticky_bit,
  output logic        skip_round,
  output logic        IV,
  output logic        DZ
);

  // --------------------------------------------------------------------------
  // Operand classification
  // --------------------------------------------------------------------------
  logic w_a_exp_zero, w_a_frac_nz, w_a_zero, w_a_inf, w_a_nan, w_a_snan;
  logic w_b_exp_zero, w_b_frac_nz, w_b_zero, w_b_inf, w_b_nan, w_b_snan;
  logic w_sgn;

  assign w_a_exp_zero = (a[30:23] == 8'd0);
  assign w_a_frac_nz  = |a[22:0];
  assign w_a_zero     = w_a_exp_zero & ~w_a_frac_nz;
  assign w_a_inf      = (&a[30:23]) & ~w_a_frac_nz;
  assign w_a_nan      = is_nan(a);
  assign w_a_snan     = w_a_nan & ~a[22];

  assign w_b_exp_zero = (b[30:23] == 8'd0);
  assign w_b_frac_nz  = |b[22:0];
  assign w_b_zero     = w_b_exp_zero & ~w_b_frac_nz;
  assign w_b_inf      = (&b[30:23]) & ~w_b_frac_nz;
  assign w_b_nan      = is_nan(b);
  assign w_b_snan     = w_b_nan & ~b[22];

  assign w_sgn = a[31] ^ b[31];

  // --------------------------------------------------------------------------
  // Mantissa normalisation; normals have the hidden bit set so lz is 0
  // --------------------------------------------------------------------------
  logic [23:0] w_a_man_raw, w_b_man_raw, w_a_man, w_b_man;
  logic [4:0]  w_lz_a, w_lz_b;
  logic [9:0]  w_a_e, w_b_e;

  assign w_a_man_raw = {~w_a_exp_zero, a[22:0]};
  assign w_b_man_raw = {~w_b_exp_zero, b[22:0]};

  leading_zero_counter #(.WIDTH(24)) u_lzc_a (
    .i_data  (w_a_man_raw),
    .o_count (w_lz_a)
  );

  leading_zero_counter #(.WIDTH(24)) u_lzc_b (
    .i_data  (w_b_man_raw),
    .o_count (w_lz_b)
  );

  assign w_a_man = w_a_man_raw << w_lz_a;
  assign w_b_man = w_b_man_raw << w_lz_b;

  // Unbiased exponents in 10-bit two's complement
  assign w_a_e = w_a_exp_zero ? (10'd0 - 10'd126 - {5'd0, w_lz_a})
                              : ({2'd0, a[30:23]} - 10'd127);
  assign w_b_e = w_b_exp_zero ? (10'd0 - 10'd126 - {5'd0, w_lz_b})
                              : ({2'd0, b[30:23]} - 10'd127);

  // Pre-doubling the dividend when ma < mb keeps the quotient in [1,2)
  logic        w_a_lt_b;
  logic [9:0]  w_exp_q;
  logic [25:0] w_rem_init;

  assign w_a_lt_b   = (w_a_man < w_b_man);
  assign w_exp_q    = w_a_e - w_b_e - {9'd0, w_a_lt_b};
  assign w_rem_init = w_a_lt_b ? {1'b0, w_a_man, 1'b0} : {2'b0, w_a_man};

  // --------------------------------------------------------------------------
  // Special-case result selection
  // --------------------------------------------------------------------------
  logic        w_spec;
  div_result_t w_spec_res;

  // Priority: NaN/invalid, inf dividend, zero divisor, zero quotient
  always_comb begin
    w_spec     = 1'b1;
    w_spec_res = '0;
    w_spec_res.rm   = rm;
    w_spec_res.skip = 1'b1;
    if (w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf)) begin
      w_spec_res.man = FPU_CANON_NAN_MAN;
      w_spec_res.exp = FPU_SPECIAL_EXP;
      w_spec_res.iv  = w_a_snan | w_b_snan | (w_a_zero & w_b_zero) |
                       (w_a_inf & w_b_inf);
    end else if (w_a_inf) begin
      w_spec_res.man = FPU_INF_MAN;
      w_spec_res.exp = FPU_SPECIAL_EXP;
      w_spec_res.sgn = w_sgn;
    end else if (w_b_zero) begin
      w_spec_res.man = FPU_INF_MAN;
      w_spec_res.exp = FPU_SPECIAL_EXP;
      w_spec_res.sgn = w_sgn;
      w_spec_res.dz  = 1'b1;
    end else if (w_a_zero | w_b_inf) begin
      w_spec_res.sgn = w_sgn;
    end else begin
      w_spec = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Restoring division step
  // --------------------------------------------------------------------------
  div_state_t  r_state;
  logic [25:0] r_rem;
  logic [23:0] r_div;
  logic [24:0] r_q;
  logic [4:0]  r_cnt;
  logic [9:0]  r_exp;
  logic        r_sgn;
  logic [2:0]  r_rm;
  logic        r_valid;
  div_result_t r_res;

  logic [25:0] w_diff, w_rem_sel, w_rem_next;
  logic        w_qbit;
  logic [24:0] w_q_next;

  assign w_diff     = r_rem - {2'b0, r_div};
  assign w_qbit     = ~w_diff[25];
  assign w_rem_sel  = w_qbit ? w_diff : r_rem;
  assign w_rem_next = w_rem_sel << 1;
  assign w_q_next   = (r_q << 1) | {24'd0, w_qbit};

  // Control FSM with registered result and handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      ready_out <= 1'b1;
      r_valid   <= 1'b0;
      r_res     <= '0;
      r_rem     <= '0;
      r_div     <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_exp     <= '0;
      r_sgn     <= 1'b0;
      r_rm      <= '0;
    end else if (flush) begin
      r_state   <= IDLE;
      ready_out <= 1'b1;
      r_valid   <= 1'b0;
      r_res     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_in) begin
            ready_out <= 1'b0;
            r_rm      <= rm;
            r_sgn     <= w_sgn;
            if (w_spec) begin
              r_state <= DONE;
              r_valid <= 1'b1;
              r_res   <= w_spec_res;
            end else begin
              r_state <= DIV;
              r_rem   <= w_rem_init;
              r_div   <= w_b_man;
              r_q     <= '0;
              r_cnt   <= DIV_ITER_LAST;
              r_exp   <= w_exp_q;
            end
          end
        end
        DIV: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd0) begin
            r_state      <= DONE;
            r_valid      <= 1'b1;
            r_res        <= '0;
            r_res.rm     <= r_rm;
            r_res.man    <= w_q_next[24:1];
            r_res.rnd    <= w_q_next[0];
            r_res.sticky <= |w_rem_next;
            r_res.exp    <= r_exp;
            r_res.sgn    <= r_sgn;
          end
        end
        DONE: begin
          if (ready_in) begin
            r_state   <= IDLE;
            ready_out <= 1'b1;
            r_valid   <= 1'b0;
            r_res     <= '0;
          end
        end
        default: begin
          r_state   <= IDLE;
          ready_out <= 1'b1;
          r_valid   <= 1'b0;
          r_res     <= '0;
        end
      endcase
    end
  end

  // A flush in the handoff cycle must hide the result immediately
  assign valid_out  = r_valid & ~flush;
  assign rm_out     = r_res.rm;
  assign man_out    = r_res.man;
  assign exp_out    = r_res.exp;
  assign sgn_out    = r_res.sgn;
  assign round_bit  = r_res.rnd;
  assign sticky_bit = r_res.sticky;
  assign skip_round = r_res.skip;
  assign IV         = r_res.iv;
  assign DZ         = r_res.dz;

endmodule
`default_nettype wire

// File: tb/tb_fp_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_divider
// Description : Directed, table-driven bench for fp_divider plus hand-written
//               backpressure and flush sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        valid_in;
  logic        ready_out;
  logic        valid_out;
  logic        ready_in;
  logic [2:0]  rm;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  rm_out;
  logic [23:0] man_out;
  logic [9:0]  exp_out;
  logic        sgn_out;
  logic        round_bit;
  logic        sticky_bit;
  logic        skip_round;
  logic        IV;
  logic        DZ;

  int n_cmp = 0;
  int n_err = 0;

  fp_divider dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .rm         (rm),
    .a          (a),
    .b          (b),
    .rm_out     (rm_out),
    .man_out    (man_out),
    .exp_out    (exp_out),
    .sgn_out    (sgn_out),
    .round_bit  (round_bit),
    .sticky_bit (sticky_bit),
    .skip_round (skip_round),
    .IV         (IV),
    .DZ         (DZ)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm;
    logic [23:0] man;
    logic [9:0]  exp;
    logic        sgn;
    logic        rnd;
    logic        stk;
    logic        skip;
    logic        iv;
    logic        dz;
    int          lat;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present operands for one edge, then count edges until valid_out (bounded)
  task automatic apply(input logic [31:0] ta, input logic [31:0] tb,
                       input logic [2:0] trm, output int lat);
    a = ta; b = tb; rm = trm; valid_in = 1'b1; lat = 0;
    do begin
      @(posedge clk); #1;
      valid_in = 1'b0;
      lat++;
    end while (!valid_out && lat < 60);
  endtask

  task automatic release_result();
    ready_in = 1'b1;
    @(posedge clk); #1;
    ready_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  lat;
    bit  seen;

    //          a             b             rm    man        exp     s  r  k  skp iv dz lat
    vecs[0]  = '{32'h40C00000, 32'h40000000, 3'd0, 24'hC00000, 10'h001, 0, 0, 0, 0, 0, 0, 26};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 3'd1, 24'hAAAAAA, 10'h3FE, 0, 1, 1, 0, 0, 0, 26};
    vecs[2]  = '{32'h3F800000, 32'h00000000, 3'd2, 24'h000000, 10'h0FF, 0, 0, 0, 1, 0, 1, 1};
    vecs[3]  = '{32'h00000000, 32'h00000000, 3'd3, 24'h400000, 10'h0FF, 0, 0, 0, 1, 1, 0, 1};
    vecs[4]  = '{32'h7F800001, 32'h3F800000, 3'd4, 24'h400000, 10'h0FF, 0, 0, 0, 1, 1, 0, 1};
    vecs[5]  = '{32'h7FC00000, 32'h3F800000, 3'd0, 24'h400000, 10'h0FF, 0, 0, 0, 1, 0, 0, 1};
    vecs[6]  = '{32'h00000001, 32'h3F800000, 3'd1, 24'h800000, 10'h36B, 0, 0, 0, 0, 0, 0, 26};
    vecs[7]  = '{32'hC0C00000, 32'h40000000, 3'd2, 24'hC00000, 10'h001, 1, 0, 0, 0, 0, 0, 26};
    vecs[8]  = '{32'h7F800000, 32'h40000000, 3'd3, 24'h000000, 10'h0FF, 0, 0, 0, 1, 0, 0, 1};
    vecs[9]  = '{32'h40000000, 32'hFF800000, 3'd4, 24'h000000, 10'h000, 1, 0, 0, 1, 0, 0, 1};
    vecs[10] = '{32'h80000000, 32'h40400000, 3'd0, 24'h000000, 10'h000, 1, 0, 0, 1, 0, 0, 1};
    vecs[11] = '{32'h7F800000, 32'h7F800000, 3'd1, 24'h400000, 10'h0FF, 0, 0, 0, 1, 1, 0, 1};
    vecs[12] = '{32'hBF800000, 32'hC0800000, 3'd2, 24'h800000, 10'h3FE, 0, 0, 0, 0, 0, 0, 26};
    vecs[13] = '{32'h3F800000, 32'h00400000, 3'd3, 24'h800000, 10'h07F, 0, 0, 0, 0, 0, 0, 26};
    vecs[14] = '{32'h7F7FFFFF, 32'h00000001, 3'd4, 24'hFFFFFF, 10'h114, 0, 0, 0, 0, 0, 0, 26};
    vecs[15] = '{32'hFFC00000, 32'h80000000, 3'd0, 24'h400000, 10'h0FF, 0, 0, 0, 1, 0, 0, 1};
    vecs[16] = '{32'hBF800000, 32'h00000000, 3'd1, 24'h000000, 10'h0FF, 1, 0, 0, 1, 0, 1, 1};

    reset = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
    rm = 3'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.ready_out", {31'd0, ready_out}, 32'd1);
    check("reset.valid_out", {31'd0, valid_out}, 32'd0);
    check("reset.result", {rm_out, man_out, exp_out, sgn_out, round_bit,
                           sticky_bit, skip_round, IV, DZ}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle.ready_out", {31'd0, ready_out}, 32'd1);

    // Table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].rm, lat);
      check($sformatf("v%0d.valid", i),   {31'd0, valid_out},  32'd1);
      check($sformatf("v%0d.latency", i), lat,                 vecs[i].lat);
      check($sformatf("v%0d.man", i),     {8'd0, man_out},     {8'd0, vecs[i].man});
      check($sformatf("v%0d.exp", i),     {22'd0, exp_out},    {22'd0, vecs[i].exp});
      check($sformatf("v%0d.flags", i),
            {25'd0, sgn_out, round_bit, sticky_bit, skip_round, IV, DZ, 1'b0},
            {25'd0, vecs[i].sgn, vecs[i].rnd, vecs[i].stk, vecs[i].skip,
             vecs[i].iv, vecs[i].dz, 1'b0});
      check($sformatf("v%0d.rm_out", i),  {29'd0, rm_out},     {29'd0, vecs[i].rm});
      check($sformatf("v%0d.ready_out", i), {31'd0, ready_out}, 32'd0);
      release_result();
      check($sformatf("v%0d.cleared", i), {30'd0, valid_out, skip_round}, 32'd0);
    end

    // Backpressure: result held stable for 10 cycles
    apply(32'h40C00000, 32'h40000000, 3'd3, lat);
    for (int c = 0; c < 10; c++) begin
      check("hold.valid", {31'd0, valid_out}, 32'd1);
      check("hold.ready_out", {31'd0, ready_out}, 32'd0);
      check("hold.result", {rm_out, man_out, exp_out, round_bit, sticky_bit},
            {3'd3, 24'hC00000, 10'h001, 1'b0, 1'b0});
      @(posedge clk); #1;
    end
    release_result();
    check("hold.release", {30'd0, valid_out, ready_out}, 32'd1);

    // Flush mid-DIV: nothing emerges and IDLE resumes next cycle
    a = 32'h40C00000; b = 32'h40000000; rm = 3'd0; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("flushdiv.busy", {31'd0, ready_out}, 32'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flushdiv.idle", {30'd0, valid_out, ready_out}, 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (valid_out) seen = 1'b1;
    end
    check("flushdiv.no_valid", {31'd0, seen}, 32'd0);
    apply(32'h40C00000, 32'h40000000, 3'd0, lat);
    check("flushdiv.restart_lat", lat, 26);
    check("flushdiv.restart_man", {8'd0, man_out}, 32'h00C00000);
    release_result();

    // Flush coincident with valid_in: operands not accepted
    a = 32'h3F800000; b = 32'h00000000; rm = 3'd0; valid_in = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0; flush = 1'b0;
    check("flushacc.idle", {30'd0, valid_out, ready_out}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("flushacc.no_valid", {31'd0, valid_out}, 32'd0);

    // Flush coincident with handoff: valid_out gated immediately, result dropped
    apply(32'h3F800000, 32'h00000000, 3'd0, lat);
    check("flushdone.valid_before", {31'd0, valid_out}, 32'd1);
    ready_in = 1'b1; flush = 1'b1;
    #1;
    check("flushdone.gated", {31'd0, valid_out}, 32'd0);
    @(posedge clk); #1;
    ready_in = 1'b0; flush = 1'b0;
    check("flushdone.idle", {29'd0, valid_out, ready_out, DZ}, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
